// File: rtl/bus_request_parser.sv
// ASCII request parser: turns "R<addr>\r" / "W<addr><data>\r" byte streams from a
// UART receiver into single-cycle bus requests, dropping and flagging bad messages.
module bus_request_parser #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  rw_o,
    output logic                  valid_o,
    output logic                  error_o
);

    localparam int A_DIGITS   = ADDR_WIDTH / 4;
    localparam int D_DIGITS   = DATA_WIDTH / 4;
    localparam int MAX_DIGITS = (A_DIGITS > D_DIGITS) ? A_DIGITS : D_DIGITS;
    localparam int DG_W       = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam int TO_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DG_W-1:0] A_LAST  = DG_W'(A_DIGITS - 1);
    localparam logic [DG_W-1:0] D_LAST  = DG_W'(D_DIGITS - 1);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_END
    } state_e;

    state_e                  state_q,   state_d;
    logic                    rw_sh_q,   rw_sh_d;
    logic [ADDR_WIDTH-1:0]   addr_sh_q, addr_sh_d;
    logic [DATA_WIDTH-1:0]   data_sh_q, data_sh_d;
    logic [DG_W-1:0]         digit_q,   digit_d;
    logic [TO_W-1:0]         tmo_q,     tmo_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic                    rw_q,      rw_d;
    logic                    valid_q,   valid_d;
    logic                    error_q,   error_d;

    logic       is_hex;
    logic [3:0] hex_val;
    logic       is_term;

    always_comb begin
        is_hex  = 1'b1;
        hex_val = '0;
        if (data_i >= "0" && data_i <= "9") begin
            hex_val = 4'(data_i - "0");
        end else if (data_i >= "A" && data_i <= "F") begin
            hex_val = 4'(data_i - "A" + 8'd10);
        end else if (data_i >= "a" && data_i <= "f") begin
            hex_val = 4'(data_i - "a" + 8'd10);
        end else begin
            is_hex = 1'b0;
        end
    end

    assign is_term = (data_i == 8'h0D) || (data_i == 8'h0A);

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        rw_sh_d   = rw_sh_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        digit_d   = digit_q;
        tmo_d     = tmo_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;

        if (state_q == S_IDLE) begin
            tmo_d   = '0;
            digit_d = '0;
            if (valid_i) begin
                if (data_i == "R" || data_i == "r") begin
                    state_d = S_ADDR;
                    rw_sh_d = 1'b0;
                end else if (data_i == "W" || data_i == "w") begin
                    state_d = S_ADDR;
                    rw_sh_d = 1'b1;
                end else if (!is_term) begin
                    error_d = 1'b1;
                end
            end
        end else if (valid_i) begin
            tmo_d = '0;
            case (state_q)
                S_ADDR: begin
                    if (is_hex) begin
                        addr_sh_d = (addr_sh_q << 4) | ADDR_WIDTH'(hex_val);
                        digit_d   = digit_q + 1'b1;
                        if (digit_q == A_LAST) begin
                            digit_d = '0;
                            state_d = rw_sh_q ? S_DATA : S_END;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    if (is_hex) begin
                        data_sh_d = (data_sh_q << 4) | DATA_WIDTH'(hex_val);
                        digit_d   = digit_q + 1'b1;
                        if (digit_q == D_LAST) begin
                            digit_d = '0;
                            state_d = S_END;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    // Commit: published registers change only here.
                    state_d = S_IDLE;
                    if (is_term) begin
                        valid_d = 1'b1;
                        addr_d  = addr_sh_q;
                        rw_d    = rw_sh_q;
                        if (rw_sh_q) begin
                            wdata_d = data_sh_q;
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                end
            endcase
        end else if (TIMEOUT_CYCLES > 0) begin
            // A byte on the expiry cycle takes the branch above, so it wins.
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TO_LAST) begin
                tmo_d   = '0;
                error_d = 1'b1;
                state_d = S_IDLE;
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rw_sh_q   <= 1'b0;
            addr_sh_q <= '0;
            data_sh_q <= '0;
            digit_q   <= '0;
            tmo_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rw_sh_q   <= rw_sh_d;
            addr_sh_q <= addr_sh_d;
            data_sh_q <= data_sh_d;
            digit_q   <= digit_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign rw_o    = rw_q;
    assign valid_o = valid_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_bus_request_parser.sv
// Self-checking bench for bus_request_parser: fixed message table, hand-written
// timeout/latency/reset sequences, and random byte streams against a message model.
module tb_bus_request_parser;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 20;
    localparam int AD = AW / 4;
    localparam int DD = DW / 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    data_i;
    logic          valid_i;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic          rw_o;
    logic          valid_o;
    logic          error_o;

    bus_request_parser #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (data_i),
        .valid_i(valid_i),
        .addr_o (addr_o),
        .wdata_o(wdata_o),
        .rw_o   (rw_o),
        .valid_o(valid_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int vcnt  = 0;
    int ecnt  = 0;

    // Reference model: tracks the message as "bytes accepted so far" plus the
    // numeric value of the address and data fields.
    bit          m_in_msg;
    bit          m_wr;
    int          m_digits;
    int unsigned m_addr_val;
    int unsigned m_data_val;
    int          m_idle;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_rw;
    logic          e_valid;
    logic          e_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] hexchar(input int d, input bit upper);
        if (d < 10) return 8'(48 + d);
        return upper ? 8'(55 + d) : 8'(87 + d);
    endfunction

    function automatic bit is_term(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A);
    endfunction

    task automatic model_reset();
        m_in_msg = 0; m_wr = 0; m_digits = 0; m_idle = 0;
        m_addr_val = 0; m_data_val = 0;
        e_addr = '0; e_wdata = '0; e_rw = 1'b0; e_valid = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        int h;
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (!m_in_msg) begin
            m_idle = 0;
            if (v) begin
                if (b == "R" || b == "r" || b == "W" || b == "w") begin
                    m_in_msg = 1; m_wr = (b == "W" || b == "w");
                    m_digits = 0; m_addr_val = 0; m_data_val = 0;
                end else if (!is_term(b)) begin
                    e_err = 1'b1;
                end
            end
        end else if (!v) begin
            m_idle++;
            if (m_idle == TO) begin
                e_err = 1'b1; m_in_msg = 0;
            end
        end else begin
            m_idle = 0;
            if (m_digits < AD + (m_wr ? DD : 0)) begin
                h = hexval(b);
                if (h < 0) begin
                    e_err = 1'b1; m_in_msg = 0;
                end else begin
                    if (m_digits < AD) m_addr_val = m_addr_val * 16 + h;
                    else               m_data_val = m_data_val * 16 + h;
                    m_digits++;
                end
            end else begin
                m_in_msg = 0;
                if (is_term(b)) begin
                    e_valid = 1'b1;
                    e_addr  = AW'(m_addr_val);
                    e_rw    = m_wr;
                    if (m_wr) e_wdata = DW'(m_data_val);
                end else begin
                    e_err = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        @(negedge clk);
        valid_i = v;
        data_i  = v ? b : 8'h00;
        @(posedge clk);
        model_step(v, b);
        #1;
        check("cycle", {addr_o, wdata_o, rw_o, valid_o, error_o},
                       {e_addr, e_wdata, e_rw, e_valid, e_err});
        if (valid_o) vcnt++;
        if (error_o) ecnt++;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    typedef struct {
        string         msg;
        int            n_valid;
        int            n_err;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rw;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [7:0] q[$];
        int         gap;
        int         kind;
        int         a;
        int         d;
        logic [7:0] junk_set[6];

        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        model_reset();
        #12;
        check("reset_state", {addr_o, wdata_o, rw_o, valid_o, error_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{"R1234\015\012",     1, 0, 16'h1234, 16'h0000, 1'b0});
        vecs.push_back('{"WBEEFcafe\015\012", 1, 0, 16'hBEEF, 16'hCAFE, 1'b1});
        vecs.push_back('{"R12G",              0, 1, 16'hBEEF, 16'hCAFE, 1'b1});
        vecs.push_back('{"R0005\012",         1, 0, 16'h0005, 16'hCAFE, 1'b0});
        vecs.push_back('{"W12\015",           0, 1, 16'h0005, 16'hCAFE, 1'b0});
        vecs.push_back('{"X",                 0, 1, 16'h0005, 16'hCAFE, 1'b0});
        vecs.push_back('{"r00ff\015",         1, 0, 16'h00FF, 16'hCAFE, 1'b0});
        vecs.push_back('{"w0001abcd\012\015", 1, 0, 16'h0001, 16'hABCD, 1'b1});
        vecs.push_back('{"R12345\015",        0, 1, 16'h0001, 16'hABCD, 1'b1});
        vecs.push_back('{"\015\012\012",      0, 0, 16'h0001, 16'hABCD, 1'b1});
        vecs.push_back('{"WFFFF\015",         0, 1, 16'h0001, 16'hABCD, 1'b1});
        vecs.push_back('{"RfFfF\012",         1, 0, 16'hFFFF, 16'hABCD, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            vcnt = 0; ecnt = 0;
            send(vecs[i].msg);
            idle(3);
            check($sformatf("vec%0d_valid_cnt", i), 64'(vcnt), 64'(vecs[i].n_valid));
            check($sformatf("vec%0d_err_cnt", i), 64'(ecnt), 64'(vecs[i].n_err));
            check($sformatf("vec%0d_outputs", i), {addr_o, wdata_o, rw_o},
                  {vecs[i].addr, vecs[i].wdata, vecs[i].rw});
        end

        // Latency: strobe visible right after the edge that samples the terminator.
        send("R00AB");
        step(1'b1, 8'h0D);
        check("latency_valid", {valid_o, error_o, addr_o}, {1'b1, 1'b0, 16'h00AB});
        step(1'b0, 8'h00);
        check("strobe_one_cycle", {valid_o, error_o}, 2'b00);

        // Timeout: 19 idle cycles then a byte survives; 20 idle cycles expire.
        vcnt = 0; ecnt = 0;
        send("R12");
        idle(TO - 1);
        send("34\015");
        idle(2);
        check("timeout_edge_valid", 64'(vcnt), 64'd1);
        check("timeout_edge_err", 64'(ecnt), 64'd0);
        check("timeout_edge_addr", 64'(addr_o), 64'h1234);
        vcnt = 0; ecnt = 0;
        send("R12");
        idle(TO);
        check("timeout_err", 64'(ecnt), 64'd1);
        send("R0042\015");
        idle(1);
        check("after_timeout_valid", 64'(vcnt), 64'd1);
        check("after_timeout_addr", 64'(addr_o), 64'h0042);

        // Asynchronous reset in the middle of a write.
        send("W0001AB");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midmsg_reset", {addr_o, wdata_o, rw_o, valid_o, error_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0; ecnt = 0;
        send("R00FF\015");
        idle(1);
        check("post_reset_valid", 64'(vcnt), 64'd1);
        check("post_reset_out", {addr_o, wdata_o, rw_o}, {16'h00FF, 16'h0000, 1'b0});

        // Random streams: mostly well-formed, some corrupted, gaps incl. timeout edge.
        junk_set = '{"G", "x", " ", 8'h0D, "z", "R"};
        for (int n = 0; n < 300; n++) begin
            q.delete();
            kind = $urandom_range(0, 9);
            if (kind <= 7) begin
                bit wr;
                wr = $urandom_range(0, 1);
                q.push_back(wr ? ($urandom_range(0, 1) ? "W" : "w")
                               : ($urandom_range(0, 1) ? "R" : "r"));
                a = $urandom_range(0, 16'hFFFF);
                d = $urandom_range(0, 16'hFFFF);
                for (int k = AD - 1; k >= 0; k--)
                    q.push_back(hexchar((a >> (4 * k)) & 15, $urandom_range(0, 1)));
                if (wr)
                    for (int k = DD - 1; k >= 0; k--)
                        q.push_back(hexchar((d >> (4 * k)) & 15, $urandom_range(0, 1)));
                q.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
                if ($urandom_range(0, 2) == 0) q.push_back(8'h0A);
                if ($urandom_range(0, 5) == 0)
                    q[$urandom_range(0, q.size() - 1)] = junk_set[$urandom_range(0, 5)];
            end else begin
                q.push_back(8'($urandom_range(32, 126)));
            end
            foreach (q[k]) begin
                gap = 0;
                case ($urandom_range(0, 39))
                    0:       gap = TO - 1;
                    1:       gap = TO;
                    2, 3, 4,
                    5, 6, 7,
                    8, 9:    gap = $urandom_range(1, 3);
                    default: gap = 0;
                endcase
                idle(gap);
                step(1'b1, q[k]);
            end
        end
        idle(TO + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
